// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration master: register map, frame
// geometry, FSM states and the queued request payload.
package spi_cfg_pkg;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_BITS = 16;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_MAX         = 7'h04;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    GAP
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cfg_req_t;

  // Write frame: leading write flag, then address, then data, MSB first.
  function automatic logic [FRAME_BITS-1:0] build_frame(input cfg_req_t r);
    return {1'b1, r.addr, r.data};
  endfunction

endpackage

// File: rtl/spi_cfg_master_if.sv
// Register-write request channel into the SPI configuration master.
interface spi_cfg_master_if;
  import spi_cfg_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              flush;

  modport master (
    output req_valid, req_addr, req_data, flush,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, flush,
    output req_ready
  );

endinterface

// File: rtl/cfg_fifo.sv
// Synchronous request queue with flush; level is the registered occupancy.
module cfg_fifo
  import spi_cfg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  cfg_req_t                   wdata,
  output cfg_req_t                   rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  cfg_req_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Flush overrides both ports so a same-cycle push is dropped.
  assign do_push = push && !full  && !flush;
  assign do_pop  = pop  && !empty && !flush;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_cfg_master.sv
// Queued SPI mode-0 register writer: 16-bit write frames, fixed sclk divider
// and a guaranteed chip-select gap between frames.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_cfg_master_if.slave              bus,
  output logic                         ncs,
  output logic                         sclk,
  output logic                         copi,
  output logic                         busy,
  output logic                         done,
  output logic                         err_addr,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES);

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [FRAME_BITS-1:0]   sh_q, sh_d;
  logic                    ncs_d, sclk_d, copi_d, done_d;
  logic                    pop, req_take, addr_legal, fifo_full, fifo_empty, div_end;
  cfg_req_t                req, head;

  assign req        = '{addr: bus.req_addr, data: bus.req_data};
  assign req_take   = bus.req_valid && bus.req_ready;
  assign addr_legal = (bus.req_addr <= ADDR_MAX);
  assign bus.req_ready = !fifo_full;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign div_end    = (div_q == DIV_W'(CLK_DIV - 1));

  cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_take && addr_legal),
    .pop   (pop),
    .flush (bus.flush),
    .wdata (req),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      sh_q     <= '0;
      ncs      <= 1'b1;
      sclk     <= 1'b0;
      copi     <= 1'b0;
      done     <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      sh_q     <= sh_d;
      ncs      <= ncs_d;
      sclk     <= sclk_d;
      copi     <= copi_d;
      done     <= done_d;
      err_addr <= req_take && !addr_legal;
    end
  end

  // Next-state and next-output logic; pins are registered from the *_d values.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    ncs_d   = ncs;
    sclk_d  = sclk;
    copi_d  = copi;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.flush) begin
          pop     = 1'b1;
          sh_d    = build_frame(head);
          copi_d  = sh_d[FRAME_BITS-1];
          ncs_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = SCK_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SCK_HI: begin
        if (div_end) begin
          div_d   = '0;
          sclk_d  = 1'b0;
          sh_d    = {sh_q[FRAME_BITS-2:0], 1'b0};
          copi_d  = sh_q[FRAME_BITS-2];
          state_d = SCK_LO;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SCK_LO: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            ncs_d   = 1'b1;
            copi_d  = 1'b0;
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            sclk_d  = 1'b1;
            state_d = SCK_HI;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      GAP: begin
        // One cycle short: the IDLE cycle that launches the next frame completes the gap.
        if (gap_q == GAP_W'(GAP_CYCLES - 2)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/spi_cfg_master.md
SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 Parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: request queue entries; power of two.
REQ-003 Parameter GAP_CYCLES, default 8: minimum ncs-high time between frames, in clk cycles; minimum 4.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  write request present.
REQ-007 req_addr  input  7  target register address.
REQ-008 req_data  input  8  register write data.
REQ-009 req_ready  output  1  queue can accept; a request is taken when req_valid and req_ready are both high.
REQ-010 flush  input  1  synchronous pulse; discards all queued, not-yet-started requests.
REQ-011 ncs  output  1  SPI chip select, active low.
REQ-012 sclk  output  1  SPI clock, mode 0 (idles low).
REQ-013 copi  output  1  SPI serial data to peripheral.
REQ-014 busy  output  1  high while a frame is in progress or the queue is non-empty.
REQ-015 done  output  1  one-cycle pulse in the cycle ncs returns high after a frame.
REQ-016 err_addr  output  1  one-cycle pulse when an accepted request has an illegal address.
REQ-017 level  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-018 Frame format is 16 bits, sent MSB first: bit15 = 1 (write), bits14:8 = addr[6:0], bits7:0 = data[7:0].
REQ-019 Legal addresses are 0x00-0x04; a request with addr > 0x04 is accepted (req_ready honoured), never enqueued or transmitted, and raises err_addr the cycle after acceptance.
REQ-020 req_ready = queue not full; no same-cycle bypass, so a full queue rejects a push even while a pop occurs.
REQ-021 FSM states: IDLE, SETUP, SCK_HI, SCK_LO, GAP.
REQ-022 IDLE: when the queue is non-empty, pop the head, drive ncs=0 and copi=frame bit15, and go to SETUP.
REQ-023 SETUP lasts CLK_DIV cycles with sclk=0, then goes to SCK_HI.
REQ-024 SCK_HI lasts CLK_DIV cycles with sclk=1; copi is held stable.
REQ-025 SCK_LO lasts CLK_DIV cycles with sclk=0; copi changes to the next bit on entry to SCK_LO.
REQ-026 After the 16th SCK_LO, ncs goes high, done pulses, and the FSM enters GAP; otherwise SCK_LO returns to SCK_HI.
REQ-027 ncs low time per frame is exactly 33*CLK_DIV cycles; exactly 16 sclk rising edges occur while ncs is low.
REQ-028 GAP holds ncs=1 and sclk=0 for GAP_CYCLES cycles, then returns to IDLE; back-to-back frames are therefore separated by exactly GAP_CYCLES cycles of ncs high.
REQ-029 copi is 0 whenever ncs is high.
REQ-030 flush empties the queue in the same cycle; a frame already started completes normally.
REQ-031 flush and a push in the same cycle: flush wins, and the pushed request is dropped (req_ready stays high).
REQ-032 level updates one cycle after a push or pop; a simultaneous push and pop leaves level unchanged.
REQ-033 Bit counter is 4 bits wide and covers 0..15 exactly; it must not wrap into a 17th bit.

Reset
REQ-034 rst_n low asynchronously forces ncs=1, sclk=0, copi=0, done=0, err_addr=0, and state=IDLE.
REQ-035 rst_n low also empties the queue (level=0) and clears all counters.
REQ-036 Reset mid-frame abandons the frame with no done pulse; the ncs rising edge seen by the peripheral is therefore possible with fewer than 16 sclk edges.

Structure
REQ-037 Shared package spi_cfg_pkg holds: register address constants ADDR_EN_OUT_7_0=0x00, ADDR_EN_OUT_15_8=0x01, ADDR_EN_PWM_7_0=0x02, ADDR_EN_PWM_15_8=0x03, ADDR_PWM_DUTY=0x04, ADDR_MAX=0x04; FRAME_BITS=16; the FSM state enum.
REQ-038 The queue is the sub-module cfg_fifo: synchronous FIFO of 15-bit entries with push, pop, flush, full, empty and level.

Verification
REQ-039 Push addr 0x00, data 0xA5 with CLK_DIV=4 -> one frame: ncs low for 132 cycles, 16 rising edges, sampled bits 0x80A5, done pulses once.
REQ-040 Push 0x02/0xFF then 0x04/0x80 back-to-back -> two frames, 0x82FF then 0x8480, with exactly 8 cycles of ncs high between them.
REQ-041 Push addr 0x05, data 0x12 -> err_addr pulses, no ncs activity, level stays 0.
REQ-042 Fill the queue with 5 pushes while the first frame runs -> 4 accepted, req_ready low on the 5th, level reaches 4.
REQ-043 flush during the 2nd of 3 queued frames -> 2nd frame completes, 3rd never sent, level=0.
REQ-044 Assert rst_n low at the 7th sclk rising edge -> ncs=1, sclk=0 and copi=0 immediately, no done pulse, level=0.
